// File: rtl/i2c_pwm_led_pkg.sv
// Shared register map and control layout for the PWM LED register block.
package i2c_pwm_led_pkg;

    localparam logic [6:0] ADDR_ID           = 7'h00;
    localparam logic [6:0] ADDR_CTRL         = 7'h01;
    localparam logic [6:0] ADDR_STATUS       = 7'h02;
    localparam logic [6:0] ADDR_TARGET_BASE  = 7'h10;
    localparam logic [6:0] ADDR_CURRENT_BASE = 7'h20;

    typedef struct packed {
        logic fade_en;
        logic enable;
    } ctrl_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: target/current duty, fade stepping and period-aligned shadow duty.
module pwm_channel
    import i2c_pwm_led_pkg::*;
#(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PWM_WIDTH-1:0] cnt,
    input  logic                 cnt_wrap,
    input  logic                 fade_en,
    input  logic                 fade_tick,
    input  logic                 target_write,
    input  logic [PWM_WIDTH-1:0] write_data,
    output logic [PWM_WIDTH-1:0] target,
    output logic [PWM_WIDTH-1:0] current,
    output logic                 fading,
    output logic                 pwm_raw
);

    localparam logic [PWM_WIDTH-1:0] STEP_ONE = PWM_WIDTH'(1);

    logic [PWM_WIDTH-1:0] target_r;
    logic [PWM_WIDTH-1:0] current_r;
    logic [PWM_WIDTH-1:0] shadow_r;
    logic [PWM_WIDTH-1:0] step_s;
    logic [PWM_WIDTH-1:0] duty_s;

    // Next fade value one step toward the (pre-write) target; never overshoots.
    always_comb begin
        step_s = current_r;
        if (current_r < target_r) begin
            step_s = current_r + STEP_ONE;
        end else if (current_r > target_r) begin
            step_s = current_r - STEP_ONE;
        end else begin
            step_s = current_r;
        end
    end

    // At cnt = 0 the freshly latched duty already applies to the whole new period.
    always_comb begin
        duty_s = shadow_r;
        if (cnt_wrap) begin
            duty_s = current_r;
        end else begin
            duty_s = shadow_r;
        end
    end

    // Duty state: target on write, current follows immediately or by fade ticks.
    always_ff @(posedge clock) begin
        if (reset) begin
            target_r  <= '0;
            current_r <= '0;
            shadow_r  <= '0;
        end else begin
            if (target_write) begin
                target_r <= write_data;
            end
            if (!fade_en) begin
                current_r <= target_write ? write_data : target_r;
            end else if (fade_tick) begin
                current_r <= step_s;
            end
            if (cnt_wrap) begin
                shadow_r <= current_r;
            end
        end
    end

    assign target  = target_r;
    assign current = current_r;
    assign fading  = (current_r != target_r);
    assign pwm_raw = (cnt < duty_s);

endmodule

// File: rtl/i2c_pwm_led_regs.sv
// Register-mapped multi-channel PWM LED controller behind the i2c_slave register port.
module i2c_pwm_led_regs
    import i2c_pwm_led_pkg::*;
#(
    parameter int         NUM_CHANNELS = 3,
    parameter int         PWM_WIDTH    = 8,
    parameter int         FADE_DIV     = 65536,
    parameter int         ACTIVE_LOW   = 1,
    parameter logic [7:0] CHIP_ID      = 8'hA5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6:0]              reg_address,
    input  logic                    reg_is_write,
    input  logic                    reg_request,
    input  logic [7:0]              reg_write_data,
    output logic                    reg_response,
    output logic [7:0]              reg_read_data,
    output logic [NUM_CHANNELS-1:0] led
);

    localparam int                    DIV_W    = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(FADE_DIV - 1);
    localparam logic [PWM_WIDTH-1:0]  CNT_LAST = PWM_WIDTH'((1 << PWM_WIDTH) - 2);
    localparam logic [NUM_CHANNELS-1:0] LED_IDLE = {NUM_CHANNELS{(ACTIVE_LOW != 0)}};

    ctrl_t                   ctrl_r;
    logic [PWM_WIDTH-1:0]    cnt_r;
    logic [DIV_W-1:0]        div_r;
    logic                    resp_r;
    logic [7:0]              rdata_r;
    logic [NUM_CHANNELS-1:0] led_r;

    logic                    cnt_wrap_s;
    logic                    fade_tick_s;
    logic [3:0]              chan_idx_s;
    logic                    chan_ok_s;
    logic                    target_page_s;
    logic                    current_page_s;
    logic                    hit_s;
    logic                    ctrl_write_s;
    logic [7:0]              rdata_s;
    logic [PWM_WIDTH-1:0]    sel_target_s;
    logic [PWM_WIDTH-1:0]    sel_current_s;
    logic [NUM_CHANNELS-1:0] target_write_s;
    logic [NUM_CHANNELS-1:0] fading_s;
    logic [NUM_CHANNELS-1:0] raw_s;
    logic [PWM_WIDTH-1:0]    target_s  [NUM_CHANNELS];
    logic [PWM_WIDTH-1:0]    current_s [NUM_CHANNELS];

    assign cnt_wrap_s     = (cnt_r == '0);
    assign fade_tick_s    = ctrl_r.fade_en && (div_r == DIV_LAST);
    assign chan_idx_s     = reg_address[3:0];
    assign chan_ok_s      = (int'(chan_idx_s) < NUM_CHANNELS);
    assign target_page_s  = (reg_address[6:4] == ADDR_TARGET_BASE[6:4]);
    assign current_page_s = (reg_address[6:4] == ADDR_CURRENT_BASE[6:4]);
    assign ctrl_write_s   = reg_request && reg_is_write && (reg_address == ADDR_CTRL);

    // Channel select muxes and per-channel target write strobes.
    always_comb begin
        sel_target_s   = '0;
        sel_current_s  = '0;
        target_write_s = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            sel_target_s      = (chan_idx_s == 4'(i)) ? target_s[i]  : sel_target_s;
            sel_current_s     = (chan_idx_s == 4'(i)) ? current_s[i] : sel_current_s;
            target_write_s[i] = reg_request && reg_is_write && target_page_s
                                && chan_ok_s && (chan_idx_s == 4'(i));
        end
    end

    // Address decode: read-only registers and absent channels do not answer writes.
    always_comb begin
        hit_s   = 1'b0;
        rdata_s = 8'h00;
        if (reg_address == ADDR_ID) begin
            hit_s   = !reg_is_write;
            rdata_s = CHIP_ID;
        end else if (reg_address == ADDR_CTRL) begin
            hit_s   = 1'b1;
            rdata_s = {6'b000000, ctrl_r};
        end else if (reg_address == ADDR_STATUS) begin
            hit_s   = !reg_is_write;
            rdata_s = 8'(fading_s);
        end else if (target_page_s && chan_ok_s) begin
            hit_s   = 1'b1;
            rdata_s = 8'(sel_target_s);
        end else if (current_page_s && chan_ok_s) begin
            hit_s   = !reg_is_write;
            rdata_s = 8'(sel_current_s);
        end else begin
            hit_s   = 1'b0;
            rdata_s = 8'h00;
        end
    end

    // Free-running PWM counter and fade divider (held at zero while fading is off).
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= '0;
            div_r <= '0;
        end else begin
            cnt_r <= (cnt_r == CNT_LAST) ? '0 : cnt_r + PWM_WIDTH'(1);
            if (!ctrl_r.fade_en || fade_tick_s) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end

    // Control register, response pipeline and registered LED outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_r  <= '0;
            resp_r  <= 1'b0;
            rdata_r <= 8'h00;
            led_r   <= LED_IDLE;
        end else begin
            resp_r <= reg_request && hit_s;
            if (reg_request && hit_s && !reg_is_write) begin
                rdata_r <= rdata_s;
            end
            if (ctrl_write_s) begin
                ctrl_r <= ctrl_t'(reg_write_data[1:0]);
            end
            led_r <= (raw_s & {NUM_CHANNELS{ctrl_r.enable}}) ^ LED_IDLE;
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        pwm_channel #(
            .PWM_WIDTH (PWM_WIDTH)
        ) u_chan (
            .clock        (clock),
            .reset        (reset),
            .cnt          (cnt_r),
            .cnt_wrap     (cnt_wrap_s),
            .fade_en      (ctrl_r.fade_en),
            .fade_tick    (fade_tick_s),
            .target_write (target_write_s[g]),
            .write_data   (reg_write_data[PWM_WIDTH-1:0]),
            .target       (target_s[g]),
            .current      (current_s[g]),
            .fading       (fading_s[g]),
            .pwm_raw      (raw_s[g])
        );
    end

    assign reg_response  = resp_r;
    assign reg_read_data = rdata_r;
    assign led           = led_r;

endmodule

// File: tb/tb_i2c_pwm_led_regs.sv
// Directed bench for i2c_pwm_led_regs with a response scoreboard and PWM duty measurement.
module tb_i2c_pwm_led_regs;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] reg_address;
    logic       reg_is_write;
    logic       reg_request;
    logic [7:0] reg_write_data;
    logic       reg_response;
    logic [7:0] reg_read_data;
    logic [2:0] led;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // Scoreboard: due cycle, mode (0 write ack, 1 compare data, 2 record data), expected data.
    int         due_q  [$];
    logic [1:0] mode_q [$];
    logic [7:0] data_q [$];
    logic [6:0] addr_q [$];
    logic [7:0] rec_q  [$];

    always #5 clock = ~clock;

    i2c_pwm_led_regs #(
        .NUM_CHANNELS (3),
        .PWM_WIDTH    (8),
        .FADE_DIV     (4),
        .ACTIVE_LOW   (1),
        .CHIP_ID      (8'hA5)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .reg_address    (reg_address),
        .reg_is_write   (reg_is_write),
        .reg_request    (reg_request),
        .reg_write_data (reg_write_data),
        .reg_response   (reg_response),
        .reg_read_data  (reg_read_data),
        .led            (led)
    );

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every cycle: a response must appear exactly when one is due, with the expected data.
    always @(negedge clock) begin
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            check($sformatf("resp@%02h", addr_q[0]), reg_response, 1);
            if (mode_q[0] == 2'd1) begin
                check($sformatf("rdata@%02h", addr_q[0]), reg_read_data, data_q[0]);
            end else if (mode_q[0] == 2'd2) begin
                rec_q.push_back(reg_read_data);
            end
            void'(due_q.pop_front());
            void'(mode_q.pop_front());
            void'(data_q.pop_front());
            void'(addr_q.pop_front());
        end else begin
            check("no_resp", reg_response, 0);
        end
    end

    task automatic acc(input logic w, input logic [6:0] a, input logic [7:0] d,
                       input logic [1:0] mode, input logic [7:0] exp, input logic expect_resp);
        reg_request    = 1'b1;
        reg_is_write   = w;
        reg_address    = a;
        reg_write_data = d;
        if (expect_resp) begin
            due_q.push_back(cyc + 1);
            mode_q.push_back(mode);
            data_q.push_back(exp);
            addr_q.push_back(a);
        end
        @(negedge clock);
    endtask

    task automatic rd(input logic [6:0] a, input logic [7:0] exp);
        acc(1'b0, a, 8'h00, 2'd1, exp, 1'b1);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        acc(1'b1, a, d, 2'd0, 8'h00, 1'b1);
    endtask

    task automatic bad(input logic w, input logic [6:0] a, input logic [7:0] d);
        acc(w, a, d, 2'd0, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        reg_request = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic measure_low(input int ch, input int exp_low, input string tag);
        int lows = 0;
        reg_request = 1'b0;
        repeat (255) begin
            @(negedge clock);
            if (led[ch] == 1'b0) lows++;
        end
        check(tag, lows, exp_low);
    endtask

    initial begin
        logic [7:0] vals [$];
        int         last_change;

        reset          = 1'b1;
        reg_request    = 1'b0;
        reg_is_write   = 1'b0;
        reg_address    = 7'h00;
        reg_write_data = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("led_reset", led, 3'b111);

        // Reset values through the register port
        rd(7'h00, 8'hA5);
        rd(7'h01, 8'h00);
        rd(7'h02, 8'h00);
        idle(1);
        check("led_idle", led, 3'b111);

        // Fade off: TARGET write moves CURRENT at once; 64/255 duty on channel 0
        wr(7'h01, 8'h01);
        wr(7'h10, 8'h40);
        rd(7'h20, 8'h40);
        rd(7'h10, 8'h40);
        idle(520);
        measure_low(0, 64, "duty40_ch0");

        // Duty extremes on channel 1, channel 2 stays at zero
        wr(7'h11, 8'h00);
        idle(520);
        measure_low(1, 0, "duty00_ch1");
        wr(7'h11, 8'hFF);
        idle(520);
        measure_low(1, 255, "dutyFF_ch1");
        measure_low(2, 0, "duty00_ch2");

        // enable = 0 forces every output off
        wr(7'h01, 8'h00);
        idle(3);
        measure_low(0, 0, "disabled_ch0");
        measure_low(1, 0, "disabled_ch1");

        // Fading: CURRENT[2] climbs 1..5, one step every 4 clocks
        wr(7'h01, 8'h03);
        wr(7'h12, 8'h05);
        rd(7'h02, 8'h04);
        repeat (30) acc(1'b0, 7'h22, 8'h00, 2'd2, 8'h00, 1'b1);
        idle(2);
        check("fade_samples", rec_q.size(), 30);
        vals = rec_q;
        if (vals.size() == 30) begin
            check("fade_start", (vals[0] <= 8'd1), 1);
            last_change = -1;
            for (int j = 1; j < 30; j++) begin
                if (vals[j] != vals[j-1]) begin
                    check($sformatf("fade_step%0d", j), vals[j], vals[j-1] + 8'd1);
                    if (last_change >= 0) check($sformatf("fade_gap%0d", j), j - last_change, 4);
                    last_change = j;
                end
            end
            check("fade_final", vals[29], 8'h05);
        end
        rd(7'h02, 8'h00);
        rd(7'h22, 8'h05);

        // Clearing fade_en snaps CURRENT to TARGET
        wr(7'h12, 8'h80);
        idle(3);
        wr(7'h01, 8'h01);
        idle(1);
        rd(7'h22, 8'h80);
        rd(7'h02, 8'h00);
        idle(2);

        // Unmapped addresses, read-only writes, absent channel: silent and harmless
        bad(1'b0, 7'h05, 8'h00);
        bad(1'b1, 7'h00, 8'h12);
        bad(1'b0, 7'h13, 8'h00);
        bad(1'b1, 7'h13, 8'h77);
        bad(1'b1, 7'h02, 8'hFF);
        bad(1'b1, 7'h20, 8'h11);
        bad(1'b0, 7'h23, 8'h00);
        idle(2);
        rd(7'h00, 8'hA5);
        rd(7'h01, 8'h01);
        rd(7'h02, 8'h00);
        rd(7'h20, 8'h40);
        idle(2);

        // Reset in the middle of a fade
        wr(7'h01, 8'h03);
        wr(7'h10, 8'hF0);
        idle(10);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("led_after_reset", led, 3'b111);
        rd(7'h02, 8'h00);
        rd(7'h20, 8'h00);
        rd(7'h21, 8'h00);
        rd(7'h22, 8'h00);
        rd(7'h01, 8'h00);
        rd(7'h10, 8'h00);
        idle(3);
        check("led_final", led, 3'b111);
        check("queue_drained", due_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
